// File: rtl/fifo_wc_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing the wide write port of the
// width-conversion FIFO between two valid/ready requesters.
module fifo_wc_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req0_valid_i,
    input  logic [2*DATA_WIDTH-1:0] req0_data_i,
    output logic                    req0_ready_o,
    input  logic                    req1_valid_i,
    input  logic [2*DATA_WIDTH-1:0] req1_data_i,
    output logic                    req1_ready_o,
    input  logic                    full_i,
    output logic                    write_o,
    output logic [2*DATA_WIDTH-1:0] write_data_o,
    output logic [1:0]              grant_o
);

    localparam int WW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ptr_reg, ptr_next;      // 0: req0 favoured, 1: req1 favoured

    logic [1:0]    valid;
    logic [WW-1:0] data [2];
    logic [1:0]    ready;
    logic          owned;
    logic          owner;
    logic          other;
    logic          beat;
    logic          at_limit;

    assign valid   = {req1_valid_i, req0_valid_i};
    assign data[0] = req0_data_i;
    assign data[1] = req1_data_i;

    assign owned    = (state_reg == ST_OWN0) || (state_reg == ST_OWN1);
    assign owner    = (state_reg == ST_OWN1);
    assign other    = ~owner;
    assign beat     = owned && valid[owner] && !full_i;
    assign at_limit = (int'(count_reg) + 1) == MAX_BURST;

    // Ready only accompanies an actual write, so a handshake is always a beat.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = beat && (owner == (gi == 1));
        end
    endgenerate

    assign req0_ready_o = ready[0];
    assign req1_ready_o = ready[1];
    assign write_o      = beat;
    assign write_data_o = owned ? data[owner] : '0;
    assign grant_o      = owned ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                count_next = '0;
                if (valid == 2'b11) begin
                    state_next = ptr_reg ? ST_OWN1 : ST_OWN0;
                end else if (valid[0]) begin
                    state_next = ST_OWN0;
                end else if (valid[1]) begin
                    state_next = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!valid[owner]) begin
                    // Owner released: hand over without a bubble, or go idle.
                    count_next = '0;
                    ptr_next   = other;
                    if (valid[other]) begin
                        state_next = other ? ST_OWN1 : ST_OWN0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (beat) begin
                    if (at_limit) begin
                        count_next = '0;
                        if (valid[other]) begin
                            ptr_next   = other;
                            state_next = other ? ST_OWN1 : ST_OWN0;
                        end
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            ptr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ptr_reg   <= ptr_next;
        end
    end

endmodule

// File: tb/tb_fifo_wc_write_arbiter.sv
// Directed bench for fifo_wc_write_arbiter: reset, streaming, round-robin
// bursts, full stalls, single-requester wrap and mid-burst reset.
module tb_fifo_wc_write_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req0_valid_i;
    logic [15:0] req0_data_i;
    logic        req0_ready_o;
    logic        req1_valid_i;
    logic [15:0] req1_data_i;
    logic        req1_ready_o;
    logic        full_i;
    logic        write_o;
    logic [15:0] write_data_o;
    logic [1:0]  grant_o;

    int vectors     = 0;
    int miscompares = 0;

    fifo_wc_write_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .full_i       (full_i),
        .write_o      (write_o),
        .write_data_o (write_data_o),
        .grant_o      (grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset;
        reset_i      = 1'b0;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        req0_data_i  = '0;
        req1_data_i  = '0;
        full_i       = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    task automatic test_reset;
        reset_i      = 1'b0;
        full_i       = 1'b0;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        req0_data_i  = 16'h1234;
        req1_data_i  = 16'h5678;
        tick();
        tick();
        #2;
        vectors++;
        if (grant_o !== 2'b00 || write_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: grant=%b write=%b want grant=00 write=0", grant_o, write_o);
        end
        vectors++;
        if ({req1_ready_o, req0_ready_o} !== 2'b00 || write_data_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outs: ready=%b data=%h want ready=00 data=0000",
                     {req1_ready_o, req0_ready_o}, write_data_o);
        end
        tick();
        reset_i = 1'b1;
        #2;
        vectors++;
        if (grant_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release_idle: grant=%b want 00", grant_o);
        end
        tick();
        #2;
        vectors++;
        if (grant_o !== 2'b01 || write_o !== 1'b1 || write_data_o !== 16'h1234 ||
            {req1_ready_o, req0_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_first_grant: grant=%b write=%b data=%h ready=%b want 01 1 1234 01",
                     grant_o, write_o, write_data_o, {req1_ready_o, req0_ready_o});
        end
        $display("test_reset done");
    endtask

    task automatic test_stream;
        logic [15:0] words [3];
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        apply_reset();
        req0_valid_i = 1'b1;
        req0_data_i  = words[0];
        for (int c = 0; c < 3; c++) begin
            tick();
            req0_data_i = words[c];
            #2;
            vectors++;
            if (grant_o !== 2'b01 || write_o !== 1'b1 || write_data_o !== words[c]) begin
                miscompares++;
                $display("FAIL stream_beat%0d: grant=%b write=%b data=%h want 01 1 %h",
                         c, grant_o, write_o, write_data_o, words[c]);
            end
        end
        tick();
        req0_valid_i = 1'b0;
        #2;
        vectors++;
        if (write_o !== 1'b0 || grant_o !== 2'b01) begin
            miscompares++;
            $display("FAIL stream_drop: write=%b grant=%b want 0 01", write_o, grant_o);
        end
        tick();
        #2;
        vectors++;
        if (grant_o !== 2'b00) begin
            miscompares++;
            $display("FAIL stream_idle: grant=%b want 00", grant_o);
        end
        $display("test_stream done");
    endtask

    task automatic test_round_robin;
        logic [1:0]  eg;
        logic [15:0] ed;
        int i0 = 0;
        int i1 = 0;
        apply_reset();
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        req0_data_i  = 16'hA000;
        req1_data_i  = 16'hB000;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c > 0) begin
                if ((((c - 1) / 4) % 2) == 0) begin
                    i0++;
                    req0_data_i = 16'hA000 + 16'(i0);
                end else begin
                    i1++;
                    req1_data_i = 16'hB000 + 16'(i1);
                end
            end
            #2;
            eg = (((c / 4) % 2) == 0) ? 2'b01 : 2'b10;
            ed = (eg == 2'b01) ? 16'hA000 + 16'(i0) : 16'hB000 + 16'(i1);
            vectors++;
            if (grant_o !== eg || write_o !== 1'b1 || write_data_o !== ed ||
                {req1_ready_o, req0_ready_o} !== eg) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: grant=%b write=%b data=%h ready=%b want %b 1 %h %b",
                         c, grant_o, write_o, write_data_o, {req1_ready_o, req0_ready_o}, eg, ed, eg);
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_full_stall;
        logic [7:0]  full_pat  = 8'b0001_1100;
        logic [7:0]  write_pat = 8'b1110_0011;
        logic [1:0]  eg;
        logic [15:0] ed;
        int i0 = 0;
        apply_reset();
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        req0_data_i  = 16'hA000;
        req1_data_i  = 16'hB000;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c > 0 && write_pat[c-1]) begin
                i0++;
                req0_data_i = 16'hA000 + 16'(i0);
            end
            full_i = full_pat[c];
            #2;
            eg = (c < 7) ? 2'b01 : 2'b10;
            ed = (c < 7) ? 16'hA000 + 16'(i0) : 16'hB000;
            vectors++;
            if (grant_o !== eg || write_o !== write_pat[c] || write_data_o !== ed ||
                {req1_ready_o, req0_ready_o} !== (write_pat[c] ? eg : 2'b00)) begin
                miscompares++;
                $display("FAIL stall_cycle%0d: grant=%b write=%b data=%h ready=%b want %b %b %h",
                         c, grant_o, write_o, write_data_o, {req1_ready_o, req0_ready_o},
                         eg, write_pat[c], ed);
            end
        end
        full_i = 1'b0;
        $display("test_full_stall done");
    endtask

    task automatic test_alone;
        logic [1:0]  eg;
        logic [15:0] ed;
        int i1 = 0;
        apply_reset();
        req1_valid_i = 1'b1;
        req1_data_i  = 16'hC000;
        req0_data_i  = 16'hD000;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c > 0 && c < 9) begin
                i1++;
                req1_data_i = 16'hC000 + 16'(i1);
            end
            if (c == 6) req0_valid_i = 1'b1;
            #2;
            eg = (c < 8) ? 2'b10 : 2'b01;
            ed = (c < 8) ? 16'hC000 + 16'(i1) : 16'hD000;
            vectors++;
            if (grant_o !== eg || write_o !== 1'b1 || write_data_o !== ed) begin
                miscompares++;
                $display("FAIL alone_cycle%0d: grant=%b write=%b data=%h want %b 1 %h",
                         c, grant_o, write_o, write_data_o, eg, ed);
            end
        end
        $display("test_alone done");
    endtask

    task automatic test_reset_mid_burst;
        apply_reset();
        req0_valid_i = 1'b1;
        req0_data_i  = 16'h0C01;
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1;
        req1_data_i  = 16'h0D01;
        #2;
        vectors++;
        if (grant_o !== 2'b01 || write_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_handover: grant=%b write=%b want 01 0", grant_o, write_o);
        end
        tick();
        #2;
        vectors++;
        if (grant_o !== 2'b10 || write_o !== 1'b1 || write_data_o !== 16'h0D01) begin
            miscompares++;
            $display("FAIL mid_own1: grant=%b write=%b data=%h want 10 1 0d01",
                     grant_o, write_o, write_data_o);
        end
        tick();
        req1_data_i  = 16'h0D02;
        req0_valid_i = 1'b1;
        req0_data_i  = 16'h0C02;
        #1;
        reset_i = 1'b0;
        #1;
        vectors++;
        if (grant_o !== 2'b00 || write_o !== 1'b0 || {req1_ready_o, req0_ready_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_async_drop: grant=%b write=%b ready=%b want 00 0 00",
                     grant_o, write_o, {req1_ready_o, req0_ready_o});
        end
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        #2;
        vectors++;
        if (grant_o !== 2'b01 || write_data_o !== 16'h0C02) begin
            miscompares++;
            $display("FAIL mid_ptr_req0: grant=%b data=%h want 01 0c02", grant_o, write_data_o);
        end
        $display("test_reset_mid_burst done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_round_robin();
        test_full_stall();
        test_alone();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
